output_deskew: RTL and testbench
================================

# output_deskew

Re-aligns the diagonally skewed result stream leaving the systolic array into whole row vectors, one per cycle, and drives the row-write port of the output matrix buffer directly downstream. Column j of each result row arrives j cycles after column 0. The block delays each column so that all MATRIX_SIZE elements emerge together, then issues a single write strobe per row. It also tracks the row index within the current tile, flags the last row of a tile, and raises a sticky error when the incoming skew pattern is inconsistent.

## Interface
- MATRIX_SIZE, 2, array dimension; number of columns per row and rows per tile (≥1, ≤255)
- DATA_WIDTH, 16, signed element width
- clk  in  1  single clock, all logic on rising edge
- rstn  in  1  synchronous, active-low reset
- clr  in  1  synchronous clear of pipeline, row counter, skew_err (tile restart)
- in_data  in  signed [DATA_WIDTH-1:0] × MATRIX_SIZE  per-column array outputs, element j from column j
- in_valid  in  [MATRIX_SIZE-1:0]  per-column valid; bit j qualifies in_data[j]
- out_data  out  signed [DATA_WIDTH-1:0] × MATRIX_SIZE  aligned row vector, feeds buffer input_data
- out_wr_en  out  1  one-cycle write strobe per aligned row, feeds buffer wr_en
- row_idx  out  [7:0]  index of the row currently presented on out_data (0..MATRIX_SIZE-1)
- tile_done  out  1  pulses with the out_wr_en of row MATRIX_SIZE-1
- skew_err  out  1  sticky: misaligned column valids detected

## Operation
- Column j passes through a delay line of (MATRIX_SIZE-1-j) registers, data and valid together. Column MATRIX_SIZE-1 has zero delay stages.
- All columns then pass through one common output register stage.
- The aligned valid vector is the set of delayed valids at the input of the output stage.
  - All bits 1: the row is accepted. out_data loads the aligned data, out_wr_en=1 next cycle, and the row counter advances.
  - All bits 0: idle. out_wr_en=0 and out_data holds its last value.
  - Mixed: out_wr_en=0, out_data holds, the row counter does not advance, and skew_err is set.
- Row counter (8 bits):
  - row_idx equals the counter value attached to the row on out_data.
  - After the row with index MATRIX_SIZE-1 is emitted, the counter wraps to 0.
  - tile_done=1 exactly in the cycle out_wr_en=1 and row_idx=MATRIX_SIZE-1.
- clr:
  - Zeroes all delay-line valids (in-flight partial rows are discarded), the row counter and skew_err.
  - out_wr_en and tile_done are 0 in the cycle after clr.
  - Delay-line data is don't-care.
  - in_valid sampled in the same cycle as clr is discarded.
- Priority: rstn > clr > normal operation.
- Data is passed through unmodified; no arithmetic or width change.
- MATRIX_SIZE=1: no delay stages, only the output register.

## Timing
- Reset (rstn=0 at a rising edge) clears:
  - out_data all elements to 0
  - out_wr_en=0, row_idx=0, tile_done=0, skew_err=0
  - all delay-line contents to 0
- Latency: if in_valid[0] of row r is sampled at edge t (and column j at edge t+j), out_wr_en=1 with that row after edge t+MATRIX_SIZE-1, i.e. visible in cycle t+MATRIX_SIZE-1..t+MATRIX_SIZE. This is one register after the last column arrives.
- Throughput: one row per cycle. Back-to-back rows with overlapping diagonals must emit on consecutive cycles with no bubbles.
- out_wr_en and tile_done are single-cycle per row; they are never held.
- skew_err asserts in the cycle after the mixed vector is registered and stays high until rstn=0 or clr=1.
- Reset mid-stream: partial rows are lost and no out_wr_en follows.

## Test plan
- Reset: hold rstn=0 for 2 cycles with in_valid=all-ones -> all outputs 0, no out_wr_en during reset or in the first cycle after.
- Single tile, MATRIX_SIZE=2: feed row0 = (5, -3) and row1 = (7, 9) diagonally, starting at cycle 0 -> out_wr_en pulses in cycles 2 and 3. out_data is (5,-3) then (7,9), row_idx is 0 then 1, tile_done=1 only in cycle 3.
- Back-to-back tiles, MATRIX_SIZE=4: 8 consecutive diagonal rows with values r*10+j -> 8 consecutive out_wr_en cycles. row_idx sequence is 0,1,2,3,0,1,2,3 and tile_done fires twice. Each row is correctly aligned.
- Skew error, MATRIX_SIZE=2: assert in_valid=2'b11 in one cycle only -> skew_err=1, no out_wr_en, row_idx unchanged. skew_err stays 1 until clr, and a valid row fed afterwards emits with row_idx=0.
- clr mid-stream, MATRIX_SIZE=4: clr asserted while 2 partial rows are in flight -> no out_wr_en for those rows, row_idx=0, and the next full row emits with row_idx=0.
- Negative extremes: columns carrying -32768 and 32767 (DATA_WIDTH=16) -> the same values appear unaltered on out_data.

Source files
------------

// File: rtl/output_deskew.sv
// Re-aligns the diagonally skewed systolic-array result stream into whole rows and
// drives one write strobe per row, with tile row tracking and a sticky skew error.
module output_deskew #(
  parameter int MATRIX_SIZE = 2,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         clr,
  input  logic signed [DATA_WIDTH-1:0] in_data  [MATRIX_SIZE],
  input  logic        [MATRIX_SIZE-1:0] in_valid,
  output logic signed [DATA_WIDTH-1:0] out_data [MATRIX_SIZE],
  output logic                         out_wr_en,
  output logic        [7:0]            row_idx,
  output logic                         tile_done,
  output logic                         skew_err
);

  localparam logic [7:0] LAST_ROW = 8'(MATRIX_SIZE - 1);

  logic signed [DATA_WIDTH-1:0] data_p0 [MATRIX_SIZE];
  logic        [MATRIX_SIZE-1:0] vld_p0;
  logic        [7:0]            row_cnt;
  logic                         row_ok;
  logic                         row_mixed;

  // Stage p0: per-column delay lines, column j delayed by MATRIX_SIZE-1-j registers
  for (genvar j = 0; j < MATRIX_SIZE; j++) begin : g_col
    localparam int D = MATRIX_SIZE - 1 - j;
    if (D == 0) begin : g_nodly
      assign data_p0[j] = in_data[j];
      assign vld_p0[j]  = in_valid[j];
    end else begin : g_dly
      logic signed [DATA_WIDTH-1:0] dly_data [D];
      logic        [D-1:0]          dly_vld;

      always_ff @(posedge clk) begin
        if (!rstn) begin
          for (int k = 0; k < D; k++) begin
            dly_data[k] <= '0;
          end
          dly_vld <= '0;
        end else begin
          dly_data[0] <= in_data[j];
          for (int k = 1; k < D; k++) begin
            dly_data[k] <= dly_data[k-1];
          end
          // clr drops every in-flight partial row, including the one sampled now
          dly_vld[0] <= in_valid[j] & ~clr;
          for (int k = 1; k < D; k++) begin
            dly_vld[k] <= dly_vld[k-1] & ~clr;
          end
        end
      end

      assign data_p0[j] = dly_data[D-1];
      assign vld_p0[j]  = dly_vld[D-1];
    end
  end

  assign row_ok    = &vld_p0;
  assign row_mixed = (|vld_p0) & ~row_ok;

  // Stage p1: common output register, row counter and status flags
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int j = 0; j < MATRIX_SIZE; j++) begin
        out_data[j] <= '0;
      end
      out_wr_en <= 1'b0;
      tile_done <= 1'b0;
      row_idx   <= '0;
      row_cnt   <= '0;
      skew_err  <= 1'b0;
    end else if (clr) begin
      out_wr_en <= 1'b0;
      tile_done <= 1'b0;
      row_idx   <= '0;
      row_cnt   <= '0;
      skew_err  <= 1'b0;
    end else begin
      out_wr_en <= row_ok;
      tile_done <= row_ok && (row_cnt == LAST_ROW);
      if (row_ok) begin
        out_data <= data_p0;
        row_idx  <= row_cnt;
        row_cnt  <= (row_cnt == LAST_ROW) ? 8'd0 : row_cnt + 8'd1;
      end
      if (row_mixed) begin
        skew_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_output_deskew.sv
// Scoreboard bench for output_deskew: a 2x2 and a 4x4 instance share clock and reset.
module tb_output_deskew;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  idx;
    logic        td;
    logic [31:0] at;
  } exp_t;

  logic clk = 1'b0;
  logic rstn, clr2, clr4;
  logic signed [15:0] d2 [2];
  logic signed [15:0] d4 [4];
  logic [1:0] v2;
  logic [3:0] v4;
  logic signed [15:0] o2 [2];
  logic signed [15:0] o4 [4];
  logic wr2, wr4, td2, td4, se2, se4;
  logic [7:0] ri2, ri4;

  int total = 0;
  int bad = 0;
  int edge_n = 0;
  int rc2 = 0;
  int rc4 = 0;
  exp_t q2[$];
  exp_t q4[$];
  logic [31:0] rows2 [8];
  logic [63:0] rows4 [8];
  logic [7:0] saved_idx;

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  output_deskew #(.MATRIX_SIZE(2), .DATA_WIDTH(16)) u2 (
    .clk(clk), .rstn(rstn), .clr(clr2), .in_data(d2), .in_valid(v2),
    .out_data(o2), .out_wr_en(wr2), .row_idx(ri2), .tile_done(td2), .skew_err(se2)
  );

  output_deskew #(.MATRIX_SIZE(4), .DATA_WIDTH(16)) u4 (
    .clk(clk), .rstn(rstn), .clr(clr4), .in_data(d4), .in_valid(v4),
    .out_data(o4), .out_wr_en(wr4), .row_idx(ri4), .tile_done(td4), .skew_err(se4)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  // Monitors: pop the oldest expected row whenever a write strobe appears
  always @(negedge clk) begin
    exp_t e;
    chk("m2_td_without_wr", {63'd0, td2 & ~wr2}, 64'd0);
    if (wr2) begin
      chk("m2_wr_expected", {63'd0, q2.size() > 0}, 64'd1);
      if (q2.size() > 0) begin
        e = q2.pop_front();
        chk("m2_data", {32'd0, o2[1], o2[0]}, e.d);
        chk("m2_row_idx", {56'd0, ri2}, {56'd0, e.idx});
        chk("m2_tile_done", {63'd0, td2}, {63'd0, e.td});
        chk("m2_latency", 64'(edge_n), {32'd0, e.at});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    chk("m4_td_without_wr", {63'd0, td4 & ~wr4}, 64'd0);
    if (wr4) begin
      chk("m4_wr_expected", {63'd0, q4.size() > 0}, 64'd1);
      if (q4.size() > 0) begin
        e = q4.pop_front();
        chk("m4_data", {o4[3], o4[2], o4[1], o4[0]}, e.d);
        chk("m4_row_idx", {56'd0, ri4}, {56'd0, e.idx});
        chk("m4_tile_done", {63'd0, td4}, {63'd0, e.td});
        chk("m4_latency", 64'(edge_n), {32'd0, e.at});
      end
    end
  end

  // Diagonal feed: at cycle c, column j carries row c-j
  task automatic feed2(input int n, input bit do_push);
    int r;
    for (int c = 0; c < n + 1; c++) begin
      @(negedge clk);
      v2 = '0;
      for (int j = 0; j < 2; j++) begin
        r = c - j;
        d2[j] = 16'sd0;
        if (r >= 0 && r < n) begin
          v2[j] = 1'b1;
          d2[j] = rows2[r][16*j +: 16];
        end
      end
      if (do_push && c < n) begin
        q2.push_back('{d: {32'd0, rows2[c]}, idx: 8'(rc2), td: (rc2 == 1),
                       at: 32'(edge_n + 2)});
        rc2 = (rc2 + 1) % 2;
      end
    end
    @(negedge clk);
    v2 = '0;
  endtask

  task automatic feed4(input int n, input bit do_push, input int stop_c, input int clr_at);
    int r;
    for (int c = 0; c < stop_c; c++) begin
      @(negedge clk);
      v4 = '0;
      clr4 = (c == clr_at);
      for (int j = 0; j < 4; j++) begin
        r = c - j;
        d4[j] = 16'sd0;
        if (r >= 0 && r < n) begin
          v4[j] = 1'b1;
          d4[j] = rows4[r][16*j +: 16];
        end
      end
      if (do_push && c < n) begin
        q4.push_back('{d: rows4[c], idx: 8'(rc4), td: (rc4 == 3), at: 32'(edge_n + 4)});
        rc4 = (rc4 + 1) % 4;
      end
    end
    @(negedge clk);
    v4 = '0;
    clr4 = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    clr2 = 1'b0;
    clr4 = 1'b0;
    v2 = '1;
    v4 = '1;
    for (int j = 0; j < 2; j++) d2[j] = 16'sh1234;
    for (int j = 0; j < 4; j++) d4[j] = 16'sh5678;

    // Reset held two cycles with all valids asserted
    @(negedge clk);
    @(negedge clk);
    chk("rst_data2", {32'd0, o2[1], o2[0]}, 64'd0);
    chk("rst_data4", {o4[3], o4[2], o4[1], o4[0]}, 64'd0);
    chk("rst_ctl2", {60'd0, wr2, td2, se2, |ri2}, 64'd0);
    chk("rst_ctl4", {60'd0, wr4, td4, se4, |ri4}, 64'd0);
    rstn = 1'b1;
    v2 = '0;
    v4 = '0;
    repeat (2) @(negedge clk);

    // Single 2x2 tile: (5,-3) then (7,9)
    rows2[0] = {16'hFFFD, 16'h0005};
    rows2[1] = {16'h0009, 16'h0007};
    feed2(2, 1'b1);
    repeat (3) @(negedge clk);

    // Eight back-to-back 4x4 rows, values r*10+j
    for (int r = 0; r < 8; r++)
      for (int j = 0; j < 4; j++)
        rows4[r][16*j +: 16] = 16'(r * 10 + j);
    feed4(8, 1'b1, 11, -1);
    repeat (5) @(negedge clk);

    // Skew error on the 2x2: both valids in one cycle only
    saved_idx = ri2;
    v2 = 2'b11;
    @(negedge clk);
    v2 = 2'b00;
    chk("skew_set", {63'd0, se2}, 64'd1);
    chk("skew_idx_hold", {56'd0, ri2}, {56'd0, saved_idx});
    repeat (3) @(negedge clk);
    chk("skew_sticky", {63'd0, se2}, 64'd1);
    chk("skew_idx_hold2", {56'd0, ri2}, {56'd0, saved_idx});
    clr2 = 1'b1;
    @(negedge clk);
    clr2 = 1'b0;
    rc2 = 0;
    chk("clr2_skew", {63'd0, se2}, 64'd0);
    chk("clr2_idx", {56'd0, ri2}, 64'd0);
    chk("clr2_wr", {62'd0, wr2, td2}, 64'd0);

    // Extremes on the 2x2 after the clear
    rows2[0] = {16'h7FFF, 16'h8000};
    rows2[1] = {16'h8000, 16'h7FFF};
    feed2(2, 1'b1);
    repeat (3) @(negedge clk);

    // clr on the 4x4 with two partial rows in flight (row0 col3 arrives with clr)
    rows4[0] = {16'd3, 16'd2, 16'd1, 16'd0};
    rows4[1] = {16'd13, 16'd12, 16'd11, 16'd10};
    saved_idx = ri4;
    chk("pre_clr4_idx", {56'd0, ri4}, 64'd3);
    feed4(2, 1'b0, 4, 3);
    rc4 = 0;
    chk("clr4_idx", {56'd0, ri4}, 64'd0);
    chk("clr4_wr", {62'd0, wr4, td4}, 64'd0);
    repeat (6) @(negedge clk);
    rows4[0] = {16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000};
    feed4(1, 1'b1, 4, -1);
    repeat (6) @(negedge clk);

    chk("q2_drained", 64'(q2.size()), 64'd0);
    chk("q4_drained", 64'(q4.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
